// File: rtl/noc_router_param.sv
// Five-port XY mesh router: per-input FIFOs, per-output round-robin arbiters and
// credit-based flow control. Ports: 0=N, 1=S, 2=E, 3=W, 4=L.
module noc_router_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned XCOORD    = 0,
    parameter int unsigned YCOORD    = 0,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CREDITS   = 4,
    parameter logic [4:0]  PORT_MASK = 5'b11111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*DATA_W-1:0] data_i,
    input  logic [4:0]          valid_i,
    output logic [4:0]          credit_o,
    output logic [5*DATA_W-1:0] data_o,
    output logic [4:0]          valid_o,
    input  logic [4:0]          credit_i,
    output logic [4:0]          err_o
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;
    localparam int unsigned CredW = $clog2(CREDITS + 1);

    localparam logic [CntW-1:0]    FullCnt = CntW'(DEPTH);
    localparam logic [CredW-1:0]   MaxCred = CredW'(CREDITS);
    localparam logic [COORD_W-1:0] MyX     = COORD_W'(XCOORD);
    localparam logic [COORD_W-1:0] MyY     = COORD_W'(YCOORD);

    localparam logic [2:0] PortN = 3'd0;
    localparam logic [2:0] PortS = 3'd1;
    localparam logic [2:0] PortE = 3'd2;
    localparam logic [2:0] PortW = 3'd3;
    localparam logic [2:0] PortL = 3'd4;

    logic [DATA_W-1:0] mem_q    [5][DEPTH];
    logic [PtrW-1:0]   wr_ptr_q [5];
    logic [PtrW-1:0]   wr_ptr_d [5];
    logic [PtrW-1:0]   rd_ptr_q [5];
    logic [PtrW-1:0]   rd_ptr_d [5];
    logic [CntW-1:0]   cnt_q    [5];
    logic [CntW-1:0]   cnt_d    [5];
    logic [CredW-1:0]  cred_q   [5];
    logic [CredW-1:0]  cred_d   [5];
    logic [2:0]        rr_q     [5];
    logic [2:0]        rr_d     [5];
    logic [DATA_W-1:0] out_q    [5];
    logic [DATA_W-1:0] out_d    [5];
    logic [4:0]        valid_q, valid_d;
    logic [4:0]        credit_q, credit_d;
    logic [4:0]        err_q, err_d;

    logic [DATA_W-1:0] head    [5];
    logic [2:0]        route   [5];
    logic [2:0]        gnt_src [5];
    logic [4:0]        nonempty, misroute, gnt_valid, pop;
    logic [4:0]        wr_en, ovf, cred_ovf;

    // Head route: dimension-ordered XY, X resolved first.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            head[p]     = mem_q[p][rd_ptr_q[p]];
            nonempty[p] = PORT_MASK[p] && (cnt_q[p] != '0);
            if (head[p][COORD_W-1:0] > MyX) begin
                route[p] = PortE;
            end else if (head[p][COORD_W-1:0] < MyX) begin
                route[p] = PortW;
            end else if (head[p][2*COORD_W-1:COORD_W] > MyY) begin
                route[p] = PortN;
            end else if (head[p][2*COORD_W-1:COORD_W] < MyY) begin
                route[p] = PortS;
            end else begin
                route[p] = PortL;
            end
            misroute[p] = nonempty[p] && !PORT_MASK[route[p]];
        end
    end

    // Per-output round-robin arbitration; misrouted heads are popped unconditionally.
    always_comb begin
        logic [2:0] idx;
        idx = '0;
        pop = misroute;
        for (int o = 0; o < 5; o++) begin
            gnt_valid[o] = 1'b0;
            gnt_src[o]   = rr_q[o];
            if (PORT_MASK[o] && (cred_q[o] != '0)) begin
                for (int k = 1; k <= 5; k++) begin
                    idx = 3'((int'(rr_q[o]) + k) % 5);
                    if (!gnt_valid[o] && nonempty[idx] && (route[idx] == 3'(o))) begin
                        gnt_valid[o] = 1'b1;
                        gnt_src[o]   = idx;
                    end
                end
            end
            if (gnt_valid[o]) begin
                pop[gnt_src[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 5; p++) begin
            // A full FIFO still accepts a write when it pops in the same cycle.
            wr_en[p] = valid_i[p] && PORT_MASK[p] && ((cnt_q[p] != FullCnt) || pop[p]);
            ovf[p]   = valid_i[p] && PORT_MASK[p] && (cnt_q[p] == FullCnt) && !pop[p];

            wr_ptr_d[p] = wr_en[p] ? wr_ptr_q[p] + PtrW'(1) : wr_ptr_q[p];
            rd_ptr_d[p] = pop[p] ? rd_ptr_q[p] + PtrW'(1) : rd_ptr_q[p];
            cnt_d[p]    = cnt_q[p] + CntW'(wr_en[p]) - CntW'(pop[p]);

            cred_d[p]   = cred_q[p];
            cred_ovf[p] = 1'b0;
            if (PORT_MASK[p]) begin
                if (gnt_valid[p] && !credit_i[p]) begin
                    cred_d[p] = cred_q[p] - CredW'(1);
                end else if (!gnt_valid[p] && credit_i[p]) begin
                    if (cred_q[p] == MaxCred) begin
                        cred_ovf[p] = 1'b1;
                    end else begin
                        cred_d[p] = cred_q[p] + CredW'(1);
                    end
                end
            end

            rr_d[p]  = gnt_valid[p] ? gnt_src[p] : rr_q[p];
            out_d[p] = gnt_valid[p] ? head[gnt_src[p]] : out_q[p];
        end
        valid_d  = gnt_valid;
        credit_d = pop;
        err_d    = err_q | ovf | misroute | cred_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 5; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
                cred_q[p]   <= MaxCred;
                rr_q[p]     <= PortL;
                out_q[p]    <= '0;
            end
            valid_q  <= '0;
            credit_q <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            cred_q   <= cred_d;
            rr_q     <= rr_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 5; p++) begin
            if (wr_en[p]) begin
                mem_q[p][wr_ptr_q[p]] <= data_i[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        data_o = '0;
        for (int p = 0; p < 5; p++) begin
            data_o[p*DATA_W +: DATA_W] = out_q[p];
        end
    end

    assign valid_o  = valid_q;
    assign credit_o = credit_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_noc_router_param.sv
// Directed bench for noc_router_param: scoreboard per output port, immediate-assert checks.
module tb_noc_router_param;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [5*W-1:0] data_i, data_o, m_data_i, m_data_o;
    logic [4:0]     valid_i, credit_i, valid_o, credit_o, err_o;
    logic [4:0]     m_valid_i, m_credit_i, m_valid_o, m_credit_o, m_err_o;

    int total = 0;
    int bad   = 0;
    int rx_cnt [5];
    int snap;

    logic [15:0] q_n[$], q_s[$], q_e[$], q_w[$], q_l[$];
    logic [15:0] mon_e;
    bit          mon_ok;

    always #5 clk = ~clk;

    noc_router_param #(
        .DATA_W(16), .COORD_W(4), .XCOORD(1), .YCOORD(1),
        .DEPTH(4), .CREDITS(4), .PORT_MASK(5'b11111)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .credit_o(credit_o),
        .data_o(data_o), .valid_o(valid_o), .credit_i(credit_i), .err_o(err_o)
    );

    noc_router_param #(
        .DATA_W(16), .COORD_W(4), .XCOORD(1), .YCOORD(1),
        .DEPTH(4), .CREDITS(4), .PORT_MASK(5'b10111)
    ) dut_m (
        .clk(clk), .rst(rst), .data_i(m_data_i), .valid_i(m_valid_i), .credit_o(m_credit_o),
        .data_o(m_data_o), .valid_o(m_valid_o), .credit_i(m_credit_i), .err_o(m_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int p, input logic [15:0] v);
        case (p)
            0: q_n.push_back(v);
            1: q_s.push_back(v);
            2: q_e.push_back(v);
            3: q_w.push_back(v);
            default: q_l.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int p, output logic [15:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        case (p)
            0: if (q_n.size() > 0) begin v = q_n.pop_front(); ok = 1'b1; end
            1: if (q_s.size() > 0) begin v = q_s.pop_front(); ok = 1'b1; end
            2: if (q_e.size() > 0) begin v = q_e.pop_front(); ok = 1'b1; end
            3: if (q_w.size() > 0) begin v = q_w.pop_front(); ok = 1'b1; end
            default: if (q_l.size() > 0) begin v = q_l.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Every delivered flit must match the head of its output's expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 5; p++) begin
                if (valid_o[p]) begin
                    rx_cnt[p]++;
                    sb_pop(p, mon_e, mon_ok);
                    total++;
                    assert (mon_ok) else begin
                        bad++;
                        $error("FAIL sb_unexpected port=%0d observed=%h expected=none",
                               p, data_o[p*W +: W]);
                    end
                    if (mon_ok) check($sformatf("sb_data_p%0d", p), 32'(data_o[p*W +: W]),
                                      32'(mon_e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [15:0] v);
        data_i[p*W +: W] = v;
        valid_i[p]       = 1'b1;
    endtask

    task automatic idle();
        valid_i = '0;
        data_i  = '0;
    endtask

    task automatic credits(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            credit_i[p] = 1'b1;
            tick();
        end
        credit_i = '0;
    endtask

    initial begin
        data_i = '0; valid_i = '0; credit_i = '0;
        m_data_i = '0; m_valid_i = '0; m_credit_i = '0;
        for (int p = 0; p < 5; p++) rx_cnt[p] = 0;

        // Reset state
        tick(); tick();
        check("rst_valid", 32'(valid_o), 32'(0));
        check("rst_credit", 32'(credit_o), 32'(0));
        check("rst_err", 32'(err_o), 32'(0));
        check("rst_data", 32'(data_o != '0), 32'(0));
        rst = 1'b0;
        tick();
        check("rst_cred_e", 32'(dut.cred_q[2]), 32'(4));

        // Single flit L -> E, latency two edges
        drive(4, 16'h0022); sb_push(2, 16'h0022);
        tick(); idle();
        check("t1_early", 32'(valid_o), 32'(0));
        tick();
        check("t1_valid", 32'(valid_o), 32'(5'b00100));
        check("t1_data", 32'(data_o[2*W +: W]), 32'(16'h0022));
        check("t1_credit", 32'(credit_o), 32'(5'b10000));
        check("t1_cred_e", 32'(dut.cred_q[2]), 32'(3));
        tick();
        check("t1_pulse", 32'({valid_o, credit_o}), 32'(0));
        credits(2, 1);
        check("t1_cred_ret", 32'(dut.cred_q[2]), 32'(4));

        // Three-way contention for L, then rotated priority
        drive(0, 16'h1011); drive(1, 16'h2011); drive(3, 16'h3011);
        sb_push(4, 16'h1011); sb_push(4, 16'h2011); sb_push(4, 16'h3011);
        tick(); idle();
        tick();
        check("t2_a_valid", 32'(valid_o), 32'(5'b10000));
        check("t2_a_credit", 32'(credit_o), 32'(5'b00001));
        tick();
        check("t2_b_credit", 32'(credit_o), 32'(5'b00010));
        tick();
        check("t2_c_credit", 32'(credit_o), 32'(5'b01000));
        credits(4, 3);
        check("t2_cred_l", 32'(dut.cred_q[4]), 32'(4));
        drive(0, 16'h4011); drive(1, 16'h5011); drive(4, 16'h6011);
        sb_push(4, 16'h6011); sb_push(4, 16'h4011); sb_push(4, 16'h5011);
        tick(); idle();
        tick();
        check("t2_d_credit", 32'(credit_o), 32'(5'b10000));
        tick();
        check("t2_e_credit", 32'(credit_o), 32'(5'b00001));
        tick();
        check("t2_f_credit", 32'(credit_o), 32'(5'b00010));
        credits(4, 3);

        // Credit exhaustion on E
        snap = rx_cnt[2];
        for (int i = 1; i <= 5; i++) begin
            drive(4, {8'(i), 8'h02}); sb_push(2, {8'(i), 8'h02});
            tick();
        end
        idle();
        tick(); tick(); tick();
        check("t3_sent4", 32'(rx_cnt[2] - snap), 32'(4));
        check("t3_cred0", 32'(dut.cred_q[2]), 32'(0));
        check("t3_stall", 32'(valid_o[2]), 32'(0));
        credits(2, 1);
        check("t3_not_yet", 32'(valid_o[2]), 32'(0));
        check("t3_cred1", 32'(dut.cred_q[2]), 32'(1));
        tick();
        check("t3_fifth", 32'(valid_o[2]), 32'(1));
        check("t3_cred_back0", 32'(dut.cred_q[2]), 32'(0));
        credits(2, 1);
        drive(4, 16'h0702); sb_push(2, 16'h0702);
        tick(); idle();
        credits(2, 1);
        check("t3_simul_valid", 32'(valid_o[2]), 32'(1));
        check("t3_simul_cred", 32'(dut.cred_q[2]), 32'(1));
        credits(2, 3);
        check("t3_cred4", 32'(dut.cred_q[2]), 32'(4));
        check("t3_err", 32'(err_o), 32'(0));

        // Input overflow on N while E is blocked
        for (int i = 8; i < 12; i++) begin
            drive(4, {8'(i), 8'h02}); sb_push(2, {8'(i), 8'h02});
            tick();
        end
        idle();
        tick(); tick(); tick();
        check("t4_cred0", 32'(dut.cred_q[2]), 32'(0));
        snap = rx_cnt[2];
        for (int i = 0; i < 5; i++) begin
            drive(0, {8'(8'hC0 + i), 8'h02});
            if (i < 4) sb_push(2, {8'(8'hC0 + i), 8'h02});
            tick();
        end
        idle();
        check("t4_err_n", 32'(err_o), 32'(5'b00001));
        check("t4_cnt_n", 32'(dut.cnt_q[0]), 32'(4));
        credits(2, 8);
        tick(); tick();
        check("t4_only4", 32'(rx_cnt[2] - snap), 32'(4));
        check("t4_cred4", 32'(dut.cred_q[2]), 32'(4));
        credits(2, 1);
        check("t4_cred_ovf_err", 32'(err_o), 32'(5'b00101));
        check("t4_cred_hold", 32'(dut.cred_q[2]), 32'(4));

        // Masked W port: misroute discard, masked input ignored
        m_data_i[4*W +: W] = 16'h0010; m_valid_i[4] = 1'b1;
        m_data_i[3*W +: W] = 16'h0022; m_valid_i[3] = 1'b1;
        @(posedge clk); #1;
        m_valid_i = '0; m_data_i = '0;
        check("t5_credit_early", 32'(m_credit_o), 32'(0));
        tick();
        check("t5_credit_l", 32'(m_credit_o), 32'(5'b10000));
        check("t5_err_l", 32'(m_err_o), 32'(5'b10000));
        check("t5_no_valid", 32'(m_valid_o), 32'(0));
        tick();
        check("t5_quiet", 32'({m_valid_o, m_credit_o}), 32'(0));
        check("t5_data0", 32'(m_data_o != '0), 32'(0));
        m_data_i[4*W +: W] = 16'h0A22; m_valid_i[4] = 1'b1;
        tick();
        m_valid_i = '0; m_data_i = '0;
        tick();
        check("t5_pass_valid", 32'(m_valid_o), 32'(5'b00100));
        check("t5_pass_data", 32'(m_data_o[2*W +: W]), 32'(16'h0A22));

        // Reset with flits buffered
        for (int i = 1; i <= 4; i++) begin
            drive(4, {8'(8'hD0 + i), 8'h02}); sb_push(2, {8'(8'hD0 + i), 8'h02});
            tick();
        end
        idle();
        tick(); tick(); tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1, {8'(8'hE0 + i), 8'h02});
            tick();
        end
        idle();
        tick(); tick();
        check("t6_buffered", 32'(dut.cnt_q[1]), 32'(3));
        check("t6_last_data", 32'(data_o[2*W +: W]), 32'(16'hD402));
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(valid_o), 32'(0));
        check("t6_rst_credit", 32'(credit_o), 32'(0));
        check("t6_rst_err", 32'(err_o), 32'(0));
        check("t6_rst_data", 32'(data_o != '0), 32'(0));
        check("t6_rst_m_err", 32'(m_err_o), 32'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_valid", 32'(valid_o), 32'(0));
            check("t6_no_credit", 32'(credit_o), 32'(0));
        end
        for (int p = 0; p < 5; p++) begin
            check($sformatf("t6_cred_p%0d", p), 32'(dut.cred_q[p]), 32'(4));
        end
        check("t6_fifo_empty", 32'(dut.cnt_q[1]), 32'(0));

        check("sb_drain_e", 32'(q_e.size()), 32'(0));
        check("sb_drain_l", 32'(q_l.size()), 32'(0));
        check("sb_drain_nsw", 32'(q_n.size() + q_s.size() + q_w.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_router_param.md
Name: noc_router_param

Overview:
- Parametrised next-generation 5-port mesh router (N, S, E, W, Local) for the NoC tile.
- Each input port has a DEPTH-deep FIFO. Packets are single-flit and routed dimension-ordered XY. Each output has its own round-robin arbiter and credit-based flow control.
- The old per-side NORTH/SOUTH/EAST/WEST flags are replaced by a port mask. Data and coordinate widths are generic.
- One instance per mesh tile; neighbours connect via flattened port buses.

Parameters:
- DATA_W, 16, flit width in bits (must be >= 2*COORD_W).
- COORD_W, 4, width of each destination coordinate field.
- XCOORD, 0, this router's X position.
- YCOORD, 0, this router's Y position.
- DEPTH, 4, input FIFO entries per port (power of 2, >= 2).
- CREDITS, 4, initial credit count per output; equals the downstream DEPTH.
- PORT_MASK, 5'b11111, bit p=1 means port p exists. Bit 4 (Local) must be 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- data_i  in  5*DATA_W  input flits; port p occupies [p*DATA_W +: DATA_W]; p: 0=N, 1=S, 2=E, 3=W, 4=L
- valid_i  in  5  flit on data_i[p] is valid
- credit_o  out  5  one-cycle pulse: one input FIFO slot freed on port p
- data_o  out  5*DATA_W  output flits, registered
- valid_o  out  5  data_o[p] valid, one-cycle pulse per flit
- credit_i  in  5  one-cycle pulse: downstream freed one slot on output p
- err_o  out  5  sticky per-port error: input overflow, misroute, or credit overflow; cleared by rst only

Behaviour:
- Reset (asynchronous, immediate): all FIFOs empty, pointers 0, credit counters = CREDITS, RR pointers = 4.
  - Outputs during and after reset: valid_o=0, data_o=0, credit_o=0, err_o=0.
  - Reset mid-packet discards all buffered flits and generates no credit pulses.
- Masked port p (PORT_MASK[p]=0): valid_i[p] ignored, FIFO tied empty, valid_o[p]=0, credit_o[p]=0, data_o[p]=0.
- Flit format: dest X = flit[COORD_W-1:0]; dest Y = flit[2*COORD_W-1:COORD_W]. Upper bits are payload, passed unmodified.
- Route computation (combinational on each FIFO head, unsigned compare), first match wins:
  - destX > XCOORD -> E
  - destX < XCOORD -> W
  - destY > YCOORD -> N
  - destY < YCOORD -> S
  - otherwise -> L
- Misroute: if the computed output is masked, the head flit is popped and discarded. credit_o pulses as for a normal pop, and err_o[input] is set.
- Arbitration, per output o, each cycle:
  - Requesters = non-empty inputs whose head routes to o.
  - Grant only if credit[o] > 0.
  - Search order starts at rr[o]+1 mod 5 and wraps; the first requester wins.
  - On grant, rr[o] <= winner. With no grant, rr[o] is unchanged.
  - An input can be granted at most one output per cycle; this is inherent, since each head has exactly one route.
- On grant, at the next edge:
  - data_o[o] <= head flit; valid_o[o] <= 1.
  - Input FIFO pops.
  - credit_o[input] <= 1, registered.
  - credit[o] decrements.
- Credit counter:
  - Grant and credit_i in the same cycle: counter unchanged.
  - credit_i only: increment. If the counter is already at CREDITS, hold and set err_o[o].
- Latency: a flit accepted at edge t is at the FIFO head in cycle t+1. With no contention and credit available, valid_o is asserted in cycle t+2 and credit_o to the upstream in cycle t+2.
- Throughput: 1 flit/cycle per output; up to 5 flits/cycle in aggregate.
- FIFO write:
  - valid_i[p] with FIFO not full: write.
  - Full and popping in the same cycle: write accepted.
  - Full and not popping: flit dropped, err_o[p] set, state unchanged.
- FIFO pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits wide.
- Arbitration, pop and route logic are combinational from registered state only; there is no combinational path from the *_i inputs to any output.

Test Plan:
- Reset, XCOORD=1, YCOORD=1: flit 16'h0022 on L at cycle 0 -> valid_o[E]=1 with data 16'h0022 at cycle 2; credit_o[L]=1 at cycle 2; credit[E] becomes 3.
- Flits on N, S, W all with dest (1,1) in the same cycle -> delivered to L in order N, S, W on 3 consecutive cycles. A repeat burst starts at W+1 -> L, N, S order, with L presenting dest (1,1).
- Credit exhaustion: 5 flits L->E with credit_i held low -> 4 sent, then the 5th stalls. A credit_i[E] pulse -> the 5th is sent 1 cycle later. A simultaneous grant and credit_i leaves the counter unchanged.
- Overflow: 5 consecutive valid_i on N with E blocked by 0 credits and all flits routed E -> 5th flit dropped, err_o[N]=1, only 4 flits emerge after credits return.
- PORT_MASK=5'b10111 (W absent), XCOORD=1, flit to dest X=0 on L -> discarded, no valid_o, credit_o[L] pulses, err_o[L]=1.
- Assert rst with 3 flits buffered -> all outputs 0 immediately; after release, no flits or credit pulses appear and credit counters read 4.
